// File: rtl/hd44780_receiver_if.sv
// ============================================================================
// Module      : hd44780_receiver_if
// Description : Character-LCD bus and buffer read port of the display model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hd44780_receiver_if;
  logic [7:0] lcd_in;
  logic       enlcd_in;
  logic       rslcd_in;
  logic       rwlcd_in;
  logic [4:0] rd_addr_in;
  logic [7:0] rd_char_out;
  logic [4:0] cursor_out;
  logic       display_on_out;
  logic       cursor_on_out;
  logic       blink_on_out;
  logic       busy_out;
  logic       write_strobe_out;
  logic       cmd_strobe_out;
  logic       error_out;
  logic       overrun_out;

  modport master (
    output lcd_in, enlcd_in, rslcd_in, rwlcd_in, rd_addr_in,
    input  rd_char_out, cursor_out, display_on_out, cursor_on_out,
           blink_on_out, busy_out, write_strobe_out, cmd_strobe_out,
           error_out, overrun_out
  );

  modport slave (
    input  lcd_in, enlcd_in, rslcd_in, rwlcd_in, rd_addr_in,
    output rd_char_out, cursor_out, display_on_out, cursor_on_out,
           blink_on_out, busy_out, write_strobe_out, cmd_strobe_out,
           error_out, overrun_out
  );
endinterface

`default_nettype wire

// File: rtl/hd44780_receiver.sv
// ============================================================================
// Module      : hd44780_receiver
// Description : HD44780-style write decoder into a 2x16 character buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hd44780_receiver #(
  parameter int EN_MIN_CYCLES = 2,
  parameter int BUSY_CYCLES   = 4
) (
  input  logic                clock_in,
  input  logic                reset_in,
  hd44780_receiver_if.slave   bus
);

  localparam int HW = (EN_MIN_CYCLES < 1) ? 1 : $clog2(EN_MIN_CYCLES + 1);
  localparam int BW = (BUSY_CYCLES < 1) ? 1 : $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t        state;
  logic          en_q, rs_q, rw_q;
  logic [7:0]    lcd_q;
  logic [HW-1:0] hi_cnt;
  logic [7:0]    cmd;
  logic          cmd_rs;
  logic [4:0]    clr_idx;
  logic [4:0]    cursor;
  logic          inc;
  logic          disp, curs, blink;
  logic [BW-1:0] cnt;
  logic          write_strobe, cmd_strobe, err, ovr;
  logic [7:0]    mem [32];
  logic [7:0]    rd_char;

  logic fall, short_pulse, busy;
  assign fall        = en_q & ~bus.enlcd_in;
  assign short_pulse = hi_cnt < HW'(EN_MIN_CYCLES);
  assign busy        = (state != IDLE) | (cnt != '0);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state        <= CLEAR;
      clr_idx      <= 5'd0;
      cursor       <= 5'd0;
      inc          <= 1'b1;
      disp         <= 1'b0;
      curs         <= 1'b0;
      blink        <= 1'b0;
      cnt          <= '0;
      write_strobe <= 1'b0;
      cmd_strobe   <= 1'b0;
      err          <= 1'b0;
      ovr          <= 1'b0;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      lcd_q        <= 8'h00;
      hi_cnt       <= '0;
      cmd          <= 8'h00;
      cmd_rs       <= 1'b0;
    end else begin
      en_q         <= bus.enlcd_in;
      lcd_q        <= bus.lcd_in;
      rs_q         <= bus.rslcd_in;
      rw_q         <= bus.rwlcd_in;
      write_strobe <= 1'b0;
      cmd_strobe   <= 1'b0;
      err          <= 1'b0;

      if (!bus.enlcd_in)
        hi_cnt <= '0;
      else if (short_pulse)
        hi_cnt <= hi_cnt + 1'b1;

      if (cnt != '0)
        cnt <= cnt - 1'b1;

      // Acceptance implies IDLE, so this never collides with the case below.
      if (fall) begin
        if (short_pulse || rw_q || busy) begin
          err <= 1'b1;
          if (busy)
            ovr <= 1'b1;
        end else begin
          cmd    <= lcd_q;
          cmd_rs <= rs_q;
          state  <= EXEC;
        end
      end

      case (state)
        EXEC: begin
          cnt   <= BW'(BUSY_CYCLES);
          state <= IDLE;
          if (cmd_rs) begin
            write_strobe <= 1'b1;
            cursor       <= inc ? cursor + 5'd1 : cursor - 5'd1;
          end else begin
            casez (cmd)
              8'b1???????: begin
                if (cmd[6:4] == 3'b000) begin
                  cursor     <= {1'b0, cmd[3:0]};
                  cmd_strobe <= 1'b1;
                end else if (cmd[6:4] == 3'b100) begin
                  cursor     <= {1'b1, cmd[3:0]};
                  cmd_strobe <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              8'b0001????: begin
                cmd_strobe <= 1'b1;
                if (!cmd[3])
                  cursor <= cmd[2] ? cursor + 5'd1 : cursor - 5'd1;
              end
              8'b00001???: begin
                cmd_strobe <= 1'b1;
                disp       <= cmd[2];
                curs       <= cmd[1];
                blink      <= cmd[0];
              end
              8'b000001??: begin
                cmd_strobe <= 1'b1;
                inc        <= cmd[1];
              end
              8'b0000001?: begin
                cmd_strobe <= 1'b1;
                cursor     <= 5'd0;
              end
              8'b00000001: begin
                cmd_strobe <= 1'b1;
                cursor     <= 5'd0;
                inc        <= 1'b1;
                clr_idx    <= 5'd0;
                state      <= CLEAR;
              end
              default: cmd_strobe <= 1'b1;
            endcase
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31)
            state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  // Buffer has no reset of its own; the CLEAR sweep initialises it.
  always_ff @(posedge clock_in) begin
    if (state == EXEC && cmd_rs)
      mem[cursor] <= cmd;
    else if (state == CLEAR)
      mem[clr_idx] <= 8'h20;
    rd_char <= mem[bus.rd_addr_in];
  end

  assign bus.rd_char_out      = rd_char;
  assign bus.cursor_out       = cursor;
  assign bus.display_on_out   = disp;
  assign bus.cursor_on_out    = curs;
  assign bus.blink_on_out     = blink;
  assign bus.busy_out         = busy;
  assign bus.write_strobe_out = write_strobe;
  assign bus.cmd_strobe_out   = cmd_strobe;
  assign bus.error_out        = err;
  assign bus.overrun_out      = ovr;

endmodule

`default_nettype wire

// File: doc/hd44780_receiver.md
# hd44780_receiver

Display-side endpoint of the character-LCD bus the vending machine drives (`lcd_out`, `enlcd_out`, `rslcd_out`, `rwlcd_out`). It decodes HD44780-style 8-bit write transfers into a 2x16 character buffer plus display state, and exposes that buffer through a read port. It is synthesizable and doubles as the self-checking display model in system benches. Everything runs in the `clock_in` domain, and bus inputs are sampled directly with no synchronizers.

## Interface
- `EN_MIN_CYCLES`, default 2: minimum consecutive cycles `enlcd_in` must stay high for a transfer to be valid.
- `BUSY_CYCLES`, default 4: busy time after each accepted transfer, in cycles.
- `clock_in` input 1: single clock; all logic is rising-edge.
- `reset_in` input 1: synchronous, active-high reset.
- `lcd_in` input 8: data bus.
- `enlcd_in` input 1: enable strobe; a transfer is captured on its falling edge.
- `rslcd_in` input 1: 0 = instruction, 1 = character data.
- `rwlcd_in` input 1: 0 = write; 1 = read, which is unsupported.
- `rd_addr_in` input 5: character buffer read address, 0-31 (0-15 = line 1, 16-31 = line 2).
- `rd_char_out` output 8: `buffer[rd_addr_in]`, registered, 1-cycle latency.
- `cursor_out` output 5: current address counter.
- `display_on_out`, `cursor_on_out`, `blink_on_out` output 1 each: display control bits D, C, B.
- `busy_out` output 1: high while clearing or while the busy counter is nonzero.
- `write_strobe_out` output 1: 1-cycle pulse when a character is stored.
- `cmd_strobe_out` output 1: 1-cycle pulse when an instruction is accepted.
- `error_out` output 1: 1-cycle pulse on a protocol violation.
- `overrun_out` output 1: sticky; set when a transfer arrives while busy, cleared only by reset.

## Operation
- Capture: `enlcd_in` is registered. A falling edge is `en_q=1 & enlcd_in=0`. On that edge, the transfer uses `lcd_in`, `rslcd_in` and `rwlcd_in` as registered on the last cycle `en_q` was high. A high-time counter saturates at `EN_MIN_CYCLES`.
- A falling edge is rejected, with an `error_out` pulse and no state change, if any of these hold:
  - high time < `EN_MIN_CYCLES`
  - `rwlcd=1`
  - `busy_out=1`; this case also sets `overrun_out`.
- States:
  - IDLE: waits for a falling edge.
  - EXEC: decodes and applies one transfer, lasting 1 cycle.
  - CLEAR: writes 0x20 to one buffer cell per cycle, addresses 0..31, lasting 32 cycles.
  - Transitions: IDLE→EXEC on a valid edge. EXEC→CLEAR for the clear instruction, otherwise EXEC→IDLE. CLEAR→IDLE after cell 31.
- Every accepted transfer loads the busy counter with `BUSY_CYCLES` in EXEC. `busy_out = (state!=IDLE) | (cnt!=0)`.
- Instruction decode (rs=0), matched on the highest set bit:
  - `1aaaaaaa`: set DDRAM address. 0x00-0x0F maps to 0-15 and 0x40-0x4F maps to 16-31. Any other value pulses `error_out` and leaves the address unchanged.
  - `01xxxxxx`: CGRAM address; accepted, no effect.
  - `001xxxxx`: function set; accepted, no effect.
  - `0001 S/C R/L xx`: if S/C=0, cursor moves ±1 (R/L=1 is +1) modulo 32. If S/C=1, accepted with no effect.
  - `00001DCB`: updates `display_on_out`, `cursor_on_out`, `blink_on_out`.
  - `000001 I/D S`: stores I/D; S is ignored.
  - `0000001x`: home; address becomes 0.
  - `00000001`: clear; address becomes 0, I/D becomes 1, then enters CLEAR.
  - `00000000`: accepted, no effect.
- Data (rs=1):
  - `buffer[cursor]` is written with the data byte and `write_strobe_out` pulses.
  - The cursor then moves +1 if I/D=1, or -1 if I/D=0, modulo 32. So 15→16, 31→0, and 0→31 when decrementing.
- `cmd_strobe_out` pulses in EXEC for every accepted instruction, including the no-op instructions.
- Reset:
  - State goes to CLEAR with `cursor_out=0` and I/D=1.
  - Display, cursor and blink bits go to 0. `overrun_out`, `error_out` and both strobes go to 0. `busy_out` goes to 1.
  - The buffer reads all 0x20 once CLEAR finishes.
  - A reset asserted mid-CLEAR or mid-transfer restarts CLEAR at cell 0. Any partially captured transfer is discarded.
- The read port is independent of the write path. When a read and a write hit the same cell in the same cycle, the read returns the old value.

## Timing
- Falling edge at cycle n (the first cycle sampled with `enlcd_in=0`): EXEC runs at n+1. Cursor, buffer and strobes are updated at n+2.
- `busy_out` deasserts `BUSY_CYCLES` cycles after EXEC for a normal transfer. After a clear, it deasserts `max(32, BUSY_CYCLES)` cycles after EXEC.
- After reset deasserts, `busy_out` stays high for 32 cycles.
- A rejected edge causes `error_out` at n+1 with no EXEC.
- `rd_char_out` is valid 1 cycle after `rd_addr_in`.

## Test plan
- Reset, wait 40 cycles, then read addresses 0-31: every cell = 0x20, `cursor_out=0`, `busy_out=0`.
- Instruction 0x0C (en high 3 cycles), wait, then data 'A' (0x41) and 'B' (0x42): `display_on_out=1`, `cursor_on_out=0`, cells 0/1 = 0x41/0x42, `cursor_out=2`, two `write_strobe_out` pulses.
- Instruction 0xCF, then data 0x5A ×2: cell 31 = 0x5A and cell 0 = 0x5A (wrap), `cursor_out=1`.
- Instruction 0x04 (decrement), set address 0x80, data 0x31: cell 0 = 0x31, `cursor_out=31`.
- Enable pulse 1 cycle high, then `rwlcd=1` transfer, then a second transfer 1 cycle after an accepted one: three `error_out` pulses, buffer unchanged, `overrun_out=1`.
- Instruction 0x01, then assert reset at CLEAR cycle 10: after 32 further cycles all cells = 0x20, `busy_out=0`, `overrun_out=0`.
